rx_align_ctrl: RTL and testbench
================================

# rx_align_ctrl

Receive-side alignment controller for the PCIe PHY lane.
- Sits directly after the serial-to-parallel converter in the clk_4f domain and sequences it.
- Hunts for the COM symbol (0xBC), asks the converter to bit-slip until bytes line up, and declares the lane active after a run of consecutive COMs.
- Once active, forwards payload bytes with a valid strobe and drops lock if COMs stop arriving.

## Interface
Parameters:
- COM, 8'hBC, comma/alignment symbol value
- LOCK_COM, 4, consecutive COM bytes required to enter ACTIVE (range 1..15)
- SLIP_WAIT, 16, bytes without a COM in SEARCH before a slip is requested (range 2..255)
- MAX_GAP, 64, bytes without a COM in ACTIVE before lock is lost (range 2..255)

Ports:
- clk_4f  in  1  byte clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- byte_in  in  8  parallel byte from serial-to-parallel converter
- byte_valid  in  1  byte_in is a new byte this cycle
- slip  out  1  one-cycle pulse: converter shifts its byte boundary by one bit
- active  out  1  lane aligned (state == ACTIVE)
- data_out  out  8  registered payload byte
- valid_out  out  1  data_out holds a new payload byte this cycle
- lock_loss_cnt  out  8  number of ACTIVE->SEARCH transitions (see Configuration)

## Operation
- States: SEARCH, LOCKING, ACTIVE. Reset state is SEARCH.
- Reset values: slip=0, active=0, data_out=8'h00, valid_out=0, lock_loss_cnt=0, all internal counters 0.
- State transitions and counter updates occur only on cycles with byte_valid=1. Otherwise all state holds, and slip/valid_out are 0.
- SEARCH:
  - byte_in==COM: com_cnt=1, gap_cnt=0. Go to LOCKING, or straight to ACTIVE if LOCK_COM==1.
  - Otherwise gap_cnt++. When gap_cnt reaches SLIP_WAIT-1, pulse slip and clear gap_cnt.
- LOCKING:
  - byte_in==COM: com_cnt++. When com_cnt reaches LOCK_COM, go to ACTIVE and clear gap_cnt.
  - Non-COM byte: go to SEARCH with com_cnt=0 and gap_cnt=0. No slip is issued on this byte.
- ACTIVE:
  - byte_in==COM: gap_cnt=0. The byte is stripped, so valid_out=0.
  - Non-COM byte: data_out<=byte_in, valid_out=1, gap_cnt++.
  - When gap_cnt reaches MAX_GAP on a non-COM byte: that byte is still forwarded, then go to SEARCH and clear counters.
  - lock_loss_cnt increments on each ACTIVE->SEARCH transition and saturates at 8'hFF.
- No payload is forwarded outside ACTIVE. The byte that completes LOCK_COM is a COM and is not forwarded.
- slip and valid_out are never asserted in the same cycle.

## Timing
- All outputs are registered.
- data_out/valid_out: 1 cycle after the byte_valid cycle that carried the byte.
- active rises 1 cycle after the byte_valid cycle of the LOCK_COM-th consecutive COM. It falls 1 cycle after the byte that exhausts MAX_GAP.
- slip: a single-cycle pulse, 1 cycle after the triggering byte. After a slip, a full SLIP_WAIT byte count must elapse before the next slip.
- reset asserted mid-operation clears outputs asynchronously, including a slip pulse in flight. After reset deasserts, the first byte_valid byte is evaluated in SEARCH.
- Counter widths: com_cnt 4 bits, gap_cnt 8 bits; no wrap is reachable within the parameter ranges.

## Configuration
- RX_ALIGN_STATS_EN defined: lock_loss_cnt is a live 8-bit saturating counter as described.
- RX_ALIGN_STATS_EN undefined: the counter logic is not compiled. The port stays present and is tied to 8'h00.

## Test plan
- Alignment: with byte_valid=1 every cycle, send AA, BC, BC, BC, BC, BB, CC, DD, EE, BC, FF.
  - active rises after the 4th BC.
  - valid_out pulses with data_out = BB, CC, DD, EE, FF.
  - The trailing BC is stripped and AA is never output.
- Broken lock run: send BC, BC, AA, BC, BC, BC, BC.
  - The AA returns the block to SEARCH.
  - active rises only after the final 4 BCs.
- Slip request: send 20 bytes of 0x55, no COM, with SLIP_WAIT=16.
  - Exactly one slip pulse, after the 16th byte.
  - A second slip only after 32 bytes.
- Loss of lock: reach ACTIVE, then send 64 non-COM bytes with MAX_GAP=64.
  - All 64 bytes are forwarded.
  - active drops 1 cycle after the 64th byte.
  - lock_loss_cnt becomes 1 (0 with the macro undefined).
- Gated input: reach ACTIVE with byte_valid toggling 1/0 every cycle.
  - Idle cycles do not advance gap_cnt.
  - valid_out is asserted only after valid bytes.
- Reset mid-stream: assert reset while in ACTIVE between clk_4f edges.
  - active, valid_out and slip drop immediately; data_out=00.
  - After release, 4 BCs are again required for lock.

Source files
------------

// File: rtl/rx_align_ctrl_if.sv
// Byte-stream bundle between the serial-to-parallel converter, the
// alignment controller and the downstream consumer.
//
// Strobe semantics: byte_in carries a new byte only in a cycle where
// byte_valid=1; there is no back-pressure. On the output side, data_out
// holds a new payload byte only in a cycle where valid_out=1, and slip
// is a one-cycle request to the converter. Consumers must ignore
// data_out whenever valid_out=0.
interface rx_align_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       slip;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state_dbg;

  modport slave (
    input  byte_in, byte_valid,
    output slip, active, data_out, valid_out, lock_loss_cnt, state_dbg
  );

  modport master (
    output byte_in, byte_valid,
    input  slip, active, data_out, valid_out, lock_loss_cnt, state_dbg
  );
endinterface

// File: rtl/rx_align_ctrl.sv
// rx_align_ctrl: receive-side lane alignment controller (clk_4f domain).
// Hunts for COM, requests bit slips from the converter until bytes line
// up, declares the lane active after LOCK_COM consecutive COMs, then
// forwards payload bytes and drops lock after MAX_GAP bytes without COM.
// Optional feature macro: RX_ALIGN_STATS_EN enables the saturating
// lock-loss counter; without it lock_loss_cnt is tied to 8'h00.
// state_dbg exposes the FSM state (0=SEARCH, 1=LOCKING, 2=ACTIVE).
module rx_align_ctrl #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter int         LOCK_COM  = 4,
  parameter int         SLIP_WAIT = 16,
  parameter int         MAX_GAP   = 64
) (
  input logic          clk_4f,
  input logic          reset,
  rx_align_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  // Counter compare points: a slip / lock loss fires on the byte that
  // would bring gap_cnt to the limit, so the limit counts bytes exactly.
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COM);
  localparam logic [7:0] SLIP_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(MAX_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] com_q, com_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] data_q, data_d;
  logic       slip_q, slip_d;
  logic       valid_q, valid_d;
  logic       active_q;
  logic       is_com;

  assign is_com = (bus.byte_in == COM);

  // Next-state and next-output logic; everything holds without byte_valid.
  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    gap_d   = gap_q;
    data_d  = data_q;
    slip_d  = 1'b0;
    valid_d = 1'b0;
    if (bus.byte_valid) begin
      case (state_q)
        SEARCH: begin
          if (is_com) begin
            com_d   = 4'd1;
            gap_d   = 8'd0;
            state_d = (LOCK_N == 4'd1) ? ACTIVE : LOCKING;
          end else if (gap_q == SLIP_LAST) begin
            slip_d = 1'b1;
            gap_d  = 8'd0;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        LOCKING: begin
          if (is_com) begin
            if (com_q + 4'd1 == LOCK_N) begin
              state_d = ACTIVE;
              com_d   = 4'd0;
              gap_d   = 8'd0;
            end else begin
              com_d = com_q + 4'd1;
            end
          end else begin
            // Broken run: restart the hunt without charging a slip.
            state_d = SEARCH;
            com_d   = 4'd0;
            gap_d   = 8'd0;
          end
        end
        ACTIVE: begin
          if (is_com) begin
            gap_d = 8'd0;
          end else begin
            data_d  = bus.byte_in;
            valid_d = 1'b1;
            if (gap_q == GAP_LAST) begin
              state_d = SEARCH;
              com_d   = 4'd0;
              gap_d   = 8'd0;
            end else begin
              gap_d = gap_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          com_d   = 4'd0;
          gap_d   = 8'd0;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      com_q    <= 4'd0;
      gap_q    <= 8'd0;
      data_q   <= 8'h00;
      slip_q   <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      com_q    <= com_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      slip_q   <= slip_d;
      valid_q  <= valid_d;
      active_q <= (state_d == ACTIVE);
    end
  end

`ifdef RX_ALIGN_STATS_EN
  logic [7:0] loss_q;

  // Count ACTIVE->SEARCH transitions, saturating at 8'hFF.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      loss_q <= 8'h00;
    end else if (state_q == ACTIVE && state_d == SEARCH && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_q;
`else
  assign bus.lock_loss_cnt = 8'h00;
`endif

  assign bus.slip      = slip_q;
  assign bus.active    = active_q;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Self-checking bench for rx_align_ctrl with default parameters
// (COM=BC, LOCK_COM=4, SLIP_WAIT=16, MAX_GAP=64).
module tb_rx_align_ctrl;

  logic clk_4f;
  logic reset;
  int   total;
  int   bad;
  int   slip_cnt;

  logic [7:0] exp_q[$];

  rx_align_ctrl_if bus ();

  rx_align_ctrl dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  // Clock and reset generation.
  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of input, then look at the registered outputs just
  // after the capturing edge and settle them against the scoreboard.
  task automatic send(input logic [7:0] b, input logic v);
    bus.byte_in    = b;
    bus.byte_valid = v;
    @(posedge clk_4f);
    #1;
    if (bus.slip === 1'b1) slip_cnt++;
    if (bus.slip === 1'b1 || bus.valid_out === 1'b1)
      check("slip_with_valid", {31'd0, bus.slip & bus.valid_out}, 32'd0);
    if (bus.valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
      end else begin
        check("data_out", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic do_reset();
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    reset          = 1'b1;
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;
    exp_q.delete();
    slip_cnt = 0;
  endtask

  // Four COMs from SEARCH; active must rise only on the fourth.
  task automatic lock_up(input string tag);
    for (int i = 1; i <= 4; i++) begin
      send(8'hBC, 1'b1);
      check(tag, {31'd0, bus.active}, {31'd0, (i == 4)});
    end
  endtask

  function automatic logic [7:0] rand_payload();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    if (r == 8'hBC) r = 8'h3C;
    return r;
  endfunction

  initial begin
    logic [7:0] seq_a[11];
    logic [7:0] seq_b[7];
    logic [7:0] exp_loss;
    total    = 0;
    bad      = 0;
    slip_cnt = 0;
    reset    = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
`ifdef RX_ALIGN_STATS_EN
    exp_loss = 8'd1;
`else
    exp_loss = 8'd0;
`endif

    // Reset values.
    do_reset();
    check("rst_slip",   {31'd0, bus.slip},        32'd0);
    check("rst_active", {31'd0, bus.active},      32'd0);
    check("rst_data",   {24'd0, bus.data_out},    32'd0);
    check("rst_valid",  {31'd0, bus.valid_out},   32'd0);
    check("rst_loss",   {24'd0, bus.lock_loss_cnt}, 32'd0);
    check("rst_state",  {30'd0, bus.state_dbg},   32'd0);

    // Alignment: AA BC BC BC BC BB CC DD EE BC FF.
    do_reset();
    seq_a = '{8'hAA, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hBC, 8'hFF};
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'hDD);
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 11; i++) begin
      send(seq_a[i], 1'b1);
      check("align_active", {31'd0, bus.active}, {31'd0, (i >= 4)});
      if (i == 9) check("align_com_stripped", {31'd0, bus.valid_out}, 32'd0);
    end
    check("align_drain", exp_q.size(), 32'd0);

    // Broken lock run: BC BC AA BC BC BC BC.
    do_reset();
    seq_b = '{8'hBC, 8'hBC, 8'hAA, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    for (int i = 0; i < 7; i++) begin
      send(seq_b[i], 1'b1);
      check("broken_active", {31'd0, bus.active}, {31'd0, (i == 6)});
      if (i == 2) check("broken_state", {30'd0, bus.state_dbg}, 32'd0);
    end
    check("broken_slips", slip_cnt, 32'd0);

    // Slip request: 32 bytes of 0x55, slips after byte 16 and byte 32.
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      send(8'h55, 1'b1);
      check("slip_pulse", {31'd0, bus.slip}, {31'd0, (i == 16 || i == 32)});
    end
    check("slip_count", slip_cnt, 32'd2);

    // Loss of lock after 64 non-COM bytes, all forwarded.
    do_reset();
    lock_up("loss_lock");
    for (int i = 1; i <= 64; i++) begin
      logic [7:0] p;
      p = rand_payload();
      exp_q.push_back(p);
      send(p, 1'b1);
      check("loss_active", {31'd0, bus.active}, {31'd0, (i < 64)});
    end
    check("loss_drain", exp_q.size(), 32'd0);
    check("loss_cnt", {24'd0, bus.lock_loss_cnt}, {24'd0, exp_loss});
    check("loss_state", {30'd0, bus.state_dbg}, 32'd0);

    // Gated input: byte_valid toggles; idles must not advance gap_cnt.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(8'hBC, 1'b1);
      check("gate_lock", {31'd0, bus.active}, {31'd0, (i == 4)});
      send(8'($urandom_range(0, 255)), 1'b0);
      check("gate_idle_valid", {31'd0, bus.valid_out}, 32'd0);
    end
    for (int i = 1; i <= 63; i++) begin
      logic [7:0] p;
      p = rand_payload();
      exp_q.push_back(p);
      send(p, 1'b1);
      send(8'($urandom_range(0, 255)), 1'b0);
      check("gate_idle_valid", {31'd0, bus.valid_out}, 32'd0);
    end
    check("gate_still_active", {31'd0, bus.active}, 32'd1);
    check("gate_drain", exp_q.size(), 32'd0);
    send(8'hBC, 1'b1);
    check("gate_com_hold", {31'd0, bus.active}, 32'd1);

    // Reset mid-stream while ACTIVE, then re-lock needs 4 COMs.
    do_reset();
    lock_up("mid_lock");
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1);
    check("mid_valid_before", {31'd0, bus.valid_out}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_active", {31'd0, bus.active},    32'd0);
    check("mid_valid",  {31'd0, bus.valid_out}, 32'd0);
    check("mid_slip",   {31'd0, bus.slip},      32'd0);
    check("mid_data",   {24'd0, bus.data_out},  32'd0);
    @(posedge clk_4f);
    #1;
    reset = 1'b0;
    lock_up("mid_relock");

    // Reset clears a slip pulse in flight.
    do_reset();
    for (int i = 1; i <= 16; i++) send(8'h55, 1'b1);
    check("flight_slip_set", {31'd0, bus.slip}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("flight_slip_clr", {31'd0, bus.slip}, 32'd0);
    @(posedge clk_4f);
    #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
